instr_loader: RTL and testbench
===============================

# instr_loader

Instruction encoder and loader for the single-cycle MIPS datapath. It accepts symbolic instruction requests (class plus register and immediate fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word. Each word is written sequentially into instruction memory, starting from a programmable base address. It is the writer-side counterpart of the control unit: it produces exactly the opcodes the control unit decodes (add, lw, sw, beq, j, addi, andi, ori), plus a nop.

## Interface
- DEPTH, 64, instruction-memory words reachable by the loader (power of two)
- ADDR_W, 6, log2(DEPTH)

- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  pulse; clear count and error, load base address, enter LOAD
- start_addr  input  ADDR_W  base word address, sampled on start
- finish  input  1  pulse; end loading session
- req_valid  input  1  request present
- req_ready  output  1  loader accepts the request this cycle
- req_kind  input  4  0 add, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, 6 andi, 7 ori, 8 nop, 9–15 illegal
- req_rs, req_rt, req_rd  input  5 each  register fields
- req_imm  input  16  immediate or branch offset, passed unmodified
- req_target  input  26  jump target field
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  32  encoded instruction
- count  output  ADDR_W+1  words written this session
- full  output  1  count == DEPTH
- done  output  1  session finished
- err  output  1  sticky; illegal kind seen since the last start

## Operation
- Encoding rules:
  - R-type add: {6'b000000, rs, rt, rd, 5'b0, 6'b100000}.
  - I-type: {op, rs, rt, imm}, with op lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101.
  - j: {6'b000010, target}.
  - nop: 32'h0.
- FSM states and transitions:
  - IDLE: req_ready=0. start → LOAD.
  - LOAD: req_ready = !full. Accepted request (req_valid && req_ready) with a legal kind → word registered, go to WRITE. Illegal kind → request consumed, err=1, nothing written, stay in LOAD. finish with no acceptance that cycle → DONE.
  - WRITE: imem_we=1 for exactly one cycle with registered addr/data; req_ready=0. Next cycle: ptr = (ptr+1) mod DEPTH, count+1. If the new count == DEPTH → FULL, else → LOAD.
  - FULL: full=1, req_ready=0. finish → DONE.
  - DONE: done=1 until start.
- Priorities and simultaneous events:
  - start has priority in every state, including the same cycle as finish or acceptance. It aborts a pending WRITE: no strobe is issued and the registered word is discarded.
  - finish asserted in WRITE is remembered. The write completes, then the FSM goes to DONE instead of LOAD.
  - finish in the same cycle as an acceptance in LOAD: the word is written first, then DONE.
  - finish in IDLE is ignored.
- Address wrap: ptr wraps modulo DEPTH. A session starting at a nonzero base writes through the top of memory and continues at 0.
- Field inputs are don't-care for the fields a kind does not use. They must not affect the encoded word.

## Timing
- Reset state: IDLE. All outputs 0 (req_ready, imem_we, imem_addr, imem_wdata, count, full, done, err); ptr = 0.
- Latency: acceptance in cycle N → imem_we high in cycle N+1 with the encoded word.
- Throughput: one word per 2 cycles. req_ready is low in WRITE.
- imem_addr and imem_wdata are registered. When imem_we=0 they hold their last value.
- count and full update in the cycle after the write strobe.
- err sets in the cycle after the illegal acceptance.
- Reset asserted mid-operation clears everything immediately (asynchronous). A strobe in flight drops that same cycle.

## Structure
- Shared package mips_ctrl_pkg: the 6-bit opcode constants and FUNCT_ADD, shared with the control unit so encoder and decoder cannot diverge. It also holds the req_kind encodings and the FSM state enum.
- One combinational sub-module, instr_field_encoder (kind plus fields → 32-bit word and legal flag). instr_loader holds the FSM, pointer, counter and output registers.

## Test plan
- start with start_addr=0, then add rd=3 rs=1 rt=2 → one imem_we cycle later, addr 0, wdata 32'h00221820; count=1.
- Back-to-back requests (lw rt=8 rs=29 imm=4; beq rs=1 rt=2 imm=16'hFFFF; j target=26'h10; ori rt=5 imm=16'h00FF) → wdata 32'h8FA80004, 32'h1022FFFF, 32'h08000010, 32'h340500FF at addr 0–3. req_ready stays low in each WRITE cycle.
- DEPTH=4, start_addr=2, four nops → writes at addr 2, 3, 0, 1; then full=1 and req_ready=0. A fifth req_valid is not accepted; finish → done=1.
- req_kind=4'hA → err=1, no imem_we, count unchanged. A following addi is written normally and err stays 1 until the next start.
- finish in the same cycle as an acceptance → the word is written, then done=1. start asserted during a WRITE → no strobe, count=0, ptr=start_addr.
- rst_n pulled low during WRITE → imem_we drops immediately and all outputs read 0. After release the FSM is in IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: opcodes, funct codes, loader request kinds
// and the loader FSM states. Encoder and control-unit decoder both use these.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_LW   = 4'd1,
        K_SW   = 4'd2,
        K_BEQ  = 4'd3,
        K_J    = 4'd4,
        K_ADDI = 4'd5,
        K_ANDI = 4'd6,
        K_ORI  = 4'd7,
        K_NOP  = 4'd8
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FULL,
        S_DONE
    } state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: symbolic request fields to a 32-bit MIPS word.
// Fields a kind does not use never reach the output word.
module instr_field_encoder
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (kind)
            K_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'b0, FUNCT_ADD};
            K_LW:   word = {OP_LW, rs, rt, imm};
            K_SW:   word = {OP_SW, rs, rt, imm};
            K_BEQ:  word = {OP_BEQ, rs, rt, imm};
            K_J:    word = {OP_J, target};
            K_ADDI: word = {OP_ADDI, rs, rt, imm};
            K_ANDI: word = {OP_ANDI, rs, rt, imm};
            K_ORI:  word = {OP_ORI, rs, rt, imm};
            K_NOP:  word = 32'h0;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts symbolic requests, encodes them and writes
// one word every two cycles into instruction memory from a base address.
module instr_loader
    import mips_ctrl_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                fin_q, fin_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                accept;
    logic [ADDR_W:0]     count_inc;

    instr_field_encoder u_enc (
        .kind   (req_kind),
        .rs     (req_rs),
        .rt     (req_rt),
        .rd     (req_rd),
        .imm    (req_imm),
        .target (req_target),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // start wins everywhere, so it also masks the handshake and the strobe
    assign full      = (count_q == DEPTH_C);
    assign req_ready = (state_q == S_LOAD) && !full && !start;
    assign imem_we   = (state_q == S_WRITE) && !start;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign count     = count_q;
    assign imem_addr = addr_q;
    assign imem_wdata = wdata_q;
    assign accept    = req_valid && req_ready;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        fin_d   = fin_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = S_LOAD;
            ptr_d   = start_addr;
            count_d = '0;
            err_d   = 1'b0;
            fin_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (accept && enc_legal) begin
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        fin_d   = finish;
                        state_d = S_WRITE;
                    end else begin
                        if (accept) err_d = 1'b1;
                        if (finish) state_d = S_DONE;
                    end
                end
                S_WRITE: begin
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_inc;
                    fin_d   = 1'b0;
                    if (fin_q || finish) state_d = S_DONE;
                    else if (count_inc == DEPTH_C) state_d = S_FULL;
                    else state_d = S_LOAD;
                end
                S_FULL: if (finish) state_d = S_DONE;
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed cases plus random sessions, with a
// scoreboard queue of expected writes consumed by an independent monitor.
module tb_instr_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          finish = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_kind = '0;
    logic [4:0]    req_rs = '0;
    logic [4:0]    req_rt = '0;
    logic [4:0]    req_rd = '0;
    logic [15:0]   req_imm = '0;
    logic [25:0]   req_target = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          done;
    logic          err;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .finish     (finish),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .req_target (req_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          writes_seen = 0;
    int          m_ptr = 0;
    int          m_count = 0;
    bit          m_err = 0;
    bit          m_done = 0;
    bit          lit_en = 0;
    logic [31:0] lit_word = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference encoding built from decimal opcodes and field positions
    function automatic logic [31:0] enc(input int k, input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic [4:0] rd,
                                        input logic [15:0] imm,
                                        input logic [25:0] tgt);
        int op;
        op = 0;
        case (k)
            0: return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'd32;
            4: return (32'd2 << 26) | 32'(tgt);
            1: op = 35;
            2: op = 43;
            3: op = 4;
            5: op = 8;
            6: op = 12;
            7: op = 13;
            default: return 32'h0;
        endcase
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && imem_we) begin
            writes_seen++;
            chk("ready_in_write", 32'(req_ready), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %h want none",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.word);
            end
        end
    end

    task automatic send(input logic [3:0] k, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt,
                        input bit fin);
        int  n;
        wr_t e;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
        req_imm = imm; req_target = tgt;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 8) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got ready 0 want 1");
                break;
            end
        end
        if (req_ready) begin
            finish = fin;
            if (k <= 4'd8) begin
                e.addr = AW'(m_ptr);
                e.word = lit_en ? lit_word : enc(int'(k), rs, rt, rd, imm, tgt);
                exp_q.push_back(e);
                m_ptr = (m_ptr + 1) % DEPTH;
                m_count++;
            end else begin
                m_err = 1;
            end
            if (fin) m_done = 1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        finish = 1'b0;
        lit_en = 0;
    endtask

    task automatic send_rand(input logic [3:0] k, input bit fin);
        send(k, 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'($urandom), fin);
    endtask

    task automatic do_start(input int a);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = AW'(a);
        @(posedge clk); #1;
        start = 1'b0;
        m_ptr = a; m_count = 0; m_err = 0; m_done = 0;
    endtask

    task automatic do_finish();
        @(posedge clk); #1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        m_done = 1;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(m_count));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_full"}, 32'(full), 32'(m_count == DEPTH));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end want finish");
        $fatal(1);
    end

    initial begin
        int wb;
        int n;
        bit fin;
        logic [3:0] k;

        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_finish();
        m_done = 0;
        chk("idle_finish_ignored", 32'(done), 32'd0);

        do_start(0);
        lit_en = 1; lit_word = 32'h00221820;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'($urandom), 26'($urandom), 0);
        settle();
        status("add");

        do_start(0);
        lit_en = 1; lit_word = 32'h8FA80004;
        send(4'd1, 5'd29, 5'd8, 5'($urandom), 16'h0004, 26'($urandom), 0);
        lit_en = 1; lit_word = 32'h1022FFFF;
        send(4'd3, 5'd1, 5'd2, 5'($urandom), 16'hFFFF, 26'($urandom), 0);
        lit_en = 1; lit_word = 32'h08000010;
        send(4'd4, 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'h10, 0);
        lit_en = 1; lit_word = 32'h340500FF;
        send(4'd7, 5'd0, 5'd5, 5'($urandom), 16'h00FF, 26'($urandom), 0);
        settle();
        status("b2b");
        chk("b2b_full_ready", 32'(req_ready), 32'd0);

        do_start(2);
        repeat (4) send_rand(4'd8, 0);
        settle();
        status("wrap");
        wb = writes_seen;
        @(posedge clk); #1;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("full_no_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("full_no_write", 32'(writes_seen), 32'(wb));
        do_finish();
        settle();
        status("full_done");

        do_start(0);
        wb = writes_seen;
        send_rand(4'hA, 0);
        settle();
        status("illegal");
        chk("illegal_no_write", 32'(writes_seen), 32'(wb));
        send_rand(4'd5, 0);
        settle();
        status("after_illegal");
        do_start(1);
        status("err_cleared");

        send_rand(4'd6, 1);
        settle();
        status("fin_accept");

        do_start(0);
        send_rand(4'd2, 0);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        m_done = 1;
        settle();
        status("fin_in_write");

        do_start(0);
        send_rand(4'd0, 0);
        wb = writes_seen;
        start = 1'b1;
        start_addr = 2'd1;
        exp_q.delete();
        m_ptr = 1; m_count = 0; m_err = 0; m_done = 0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abort_no_strobe", 32'(writes_seen), 32'(wb));
        status("abort");
        send_rand(4'd8, 0);
        settle();
        status("abort_next");

        do_start(3);
        send_rand(4'd7, 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 0; m_count = 0; m_err = 0; m_done = 0;
        @(negedge clk);
        chk("rst_idle_ready", 32'(req_ready), 32'd0);
        status("rst_idle");

        for (int s = 0; s < 16; s++) begin
            do_start(int'($urandom_range(0, DEPTH - 1)));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                if (m_count == DEPTH) break;
                if ($urandom_range(0, 5) == 0) k = 4'($urandom_range(9, 15));
                else k = 4'($urandom_range(0, 8));
                fin = (i == n - 1) && ($urandom_range(0, 1) == 1);
                send_rand(k, fin);
                if (fin) break;
            end
            settle();
            status("rand_mid");
            if (!m_done) do_finish();
            settle();
            status("rand_end");
        end

        settle();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
